// File: rtl/rsa_stream_engine_pkg.sv
// Shared definitions for the RSA stream engine: default operand width,
// command opcodes and the state encodings of the engine and exponentiator.
package rsa_stream_engine_pkg;

    localparam int BITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_LOAD_N   = 2'd0,
        OP_LOAD_R2  = 2'd1,
        OP_LOAD_EXP = 2'd2,
        OP_RUN      = 2'd3
    } opcode_t;

    typedef enum logic [2:0] {
        HDR,
        PAYLOAD,
        START,
        WAIT,
        SEND,
        ERR
    } state_t;

    typedef enum logic [2:0] {
        EX_IDLE,
        EX_TO_M,
        EX_TO_X,
        EX_SQR,
        EX_MUL,
        EX_FROM,
        EX_DONE
    } exp_state_t;

endpackage

// File: rtl/rsa_stream_engine_mod_exp.sv
// Montgomery square-and-multiply modular exponentiation, one radix-2 step per cycle.
// The modulus must be odd, operands below it, and r2 = 2^(2*BITS) mod n.
module mod_exp
    import rsa_stream_engine_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [BITS-1:0] m,
    input  logic [BITS-1:0] e,
    input  logic [BITS-1:0] n,
    input  logic [BITS-1:0] r2,
    output logic [BITS-1:0] out,
    output logic            out_valid
);

    localparam int TW    = BITS + 2;
    localparam int IDX_W = $clog2(BITS);
    localparam int MC_W  = $clog2(BITS + 1);

    exp_state_t state, state_nx;
    logic [MC_W-1:0]  mcnt;
    logic [IDX_W-1:0] bit_idx;
    logic [BITS-1:0]  a_sh, x, mm, a_src, b_sel, res;
    logic [TW-1:0]    t, t_add, t_red, t_step;
    logic             mul_state, mul_last, bit_set, bit_zero;

    assign mul_state = state inside {EX_TO_M, EX_TO_X, EX_SQR, EX_MUL, EX_FROM};
    assign mul_last  = mul_state && (mcnt == MC_W'(BITS));
    assign bit_set   = e[bit_idx];
    assign bit_zero  = (bit_idx == '0);

    // Each multiply spends mcnt==0 loading its operand, then BITS reduction steps;
    // t stays below 2n, so a single conditional subtraction finishes it.
    always_comb begin
        a_src = x;
        b_sel = x;
        case (state)
            EX_TO_M: begin a_src = m;          b_sel = r2; end
            EX_TO_X: begin a_src = BITS'(1);   b_sel = r2; end
            EX_MUL:  b_sel = mm;
            EX_FROM: b_sel = BITS'(1);
            default: ;
        endcase
        t_add  = t + (a_sh[0] ? TW'(b_sel) : '0);
        t_red  = t_add + (t_add[0] ? TW'(n) : '0);
        t_step = t_red >> 1;
        res    = (t_step >= TW'(n)) ? BITS'(t_step - TW'(n)) : BITS'(t_step);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EX_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            EX_IDLE: if (in_valid) state_nx = EX_TO_M;
            EX_TO_M: if (mul_last) state_nx = EX_TO_X;
            EX_TO_X: if (mul_last) state_nx = EX_SQR;
            EX_SQR:  if (mul_last) state_nx = bit_set ? EX_MUL : (bit_zero ? EX_FROM : EX_SQR);
            EX_MUL:  if (mul_last) state_nx = bit_zero ? EX_FROM : EX_SQR;
            EX_FROM: if (mul_last) state_nx = EX_DONE;
            EX_DONE: state_nx = EX_IDLE;
            default: state_nx = EX_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == EX_DONE);
        out       = x;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt    <= '0;
            bit_idx <= '0;
            a_sh    <= '0;
            t       <= '0;
            x       <= '0;
            mm      <= '0;
        end else begin
            if (state == EX_IDLE && in_valid) bit_idx <= IDX_W'(BITS - 1);
            if (mul_state) begin
                if (mcnt == '0) begin
                    a_sh <= a_src;
                    t    <= '0;
                end else begin
                    a_sh <= a_sh >> 1;
                    t    <= t_step;
                end
                mcnt <= mul_last ? '0 : mcnt + 1'b1;
            end
            if (mul_last) begin
                if (state == EX_TO_M) mm <= res;
                else                  x  <= res;
                if ((state == EX_SQR && !bit_set && !bit_zero) || (state == EX_MUL && !bit_zero))
                    bit_idx <= bit_idx - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_stream_engine.sv
// Word-stream front end for RSA: loads modulus, R^2 and exponent slots from
// headered little-endian payloads and streams each mod_exp result back out.
module rsa_stream_engine
    import rsa_stream_engine_pkg::*;
#(
    parameter int BITS    = BITS_DEFAULT,
    parameter int W       = 8,
    parameter int NSLOT   = 2,
    parameter int MAX_CYC = 65536
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    localparam int K      = BITS / W;
    localparam int CNT_W  = $clog2(K + 1);
    localparam int WD_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam int SLOT_W = W - 2;

    state_t              state, state_nx;
    opcode_t             op;
    logic [SLOT_W-1:0]   slot;
    logic [CNT_W-1:0]    cnt;
    logic [WD_W-1:0]     wd;
    logic [BITS-1:0]     asm_reg, asm_next, n, r2, m, result, e_sel, me_out;
    logic [BITS-1:0]     exp_reg [NSLOT];
    logic [NSLOT-1:0]    e_ok;
    logic                n_ok, r2_ok, e_ok_sel, live;
    logic                me_start, me_valid;
    logic                xfer_in, xfer_out, last_in, last_out, slot_ok, run_ok;

    always_comb begin
        e_sel    = '0;
        e_ok_sel = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (32'(slot) == i) begin
                e_sel    = exp_reg[i];
                e_ok_sel = e_ok[i];
            end
        end
    end

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;
    assign last_in  = (state == PAYLOAD) && xfer_in && (cnt == CNT_W'(K - 1));
    assign last_out = xfer_out && (cnt == CNT_W'(K - 1));
    assign slot_ok  = 32'(slot) < NSLOT;
    assign run_ok   = slot_ok && n_ok && r2_ok && e_ok_sel;
    assign asm_next = asm_reg | (BITS'(in_data) << (W * 32'(cnt)));
    assign out_data = result[W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HDR;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            HDR:     if (xfer_in) state_nx = PAYLOAD;
            PAYLOAD: if (last_in) begin
                case (op)
                    OP_LOAD_EXP: state_nx = slot_ok ? HDR : ERR;
                    OP_RUN:      state_nx = run_ok ? START : ERR;
                    default:     state_nx = HDR;
                endcase
            end
            START:   state_nx = WAIT;
            WAIT:    if (me_valid) state_nx = SEND;
                     else if (wd == WD_W'(MAX_CYC - 1)) state_nx = ERR;
            SEND:    if (last_out) state_nx = HDR;
            ERR:     state_nx = HDR;
            default: state_nx = HDR;
        endcase
    end

    // live keeps in_ready low while reset is held even though the state is HDR.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        err       = 1'b0;
        me_start  = 1'b0;
        case (state)
            HDR:     begin in_ready = live; busy = 1'b0; end
            PAYLOAD: in_ready = live;
            START:   me_start = 1'b1;
            SEND:    out_valid = 1'b1;
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live    <= 1'b0;
            op      <= OP_LOAD_N;
            slot    <= '0;
            cnt     <= '0;
            wd      <= '0;
            asm_reg <= '0;
            n       <= '0;
            r2      <= '0;
            m       <= '0;
            result  <= '0;
            n_ok    <= 1'b0;
            r2_ok   <= 1'b0;
            e_ok    <= '0;
            for (int i = 0; i < NSLOT; i++) exp_reg[i] <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                HDR: if (xfer_in) begin
                    op      <= opcode_t'(in_data[W-1:W-2]);
                    slot    <= in_data[W-3:0];
                    cnt     <= '0;
                    asm_reg <= '0;
                end
                PAYLOAD: if (xfer_in) begin
                    asm_reg <= asm_next;
                    cnt     <= cnt + 1'b1;
                    if (last_in) begin
                        case (op)
                            OP_LOAD_N:  begin n  <= asm_next; n_ok  <= 1'b1; end
                            OP_LOAD_R2: begin r2 <= asm_next; r2_ok <= 1'b1; end
                            OP_LOAD_EXP: begin
                                for (int i = 0; i < NSLOT; i++) begin
                                    if (32'(slot) == i) begin
                                        exp_reg[i] <= asm_next;
                                        e_ok[i]    <= 1'b1;
                                    end
                                end
                            end
                            OP_RUN: if (run_ok) m <= asm_next;
                            default: ;
                        endcase
                    end
                end
                START: wd <= '0;
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (me_valid) begin
                        result <= me_out;
                        cnt    <= '0;
                    end
                end
                SEND: if (xfer_out) begin
                    result <= result >> W;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    mod_exp #(.BITS(BITS)) rsa_exp_0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (me_start),
        .m         (m),
        .e         (e_sel),
        .n         (n),
        .r2        (r2),
        .out       (me_out),
        .out_valid (me_valid)
    );

endmodule

// File: tb/tb_rsa_stream_engine.sv
// Directed bench for rsa_stream_engine using the textbook RSA key n=3233, e=17, d=2753;
// a second instance with a 16-cycle watchdog covers the timeout path.
module tb_rsa_stream_engine;

    localparam logic [31:0] N_KEY  = 32'd3233;
    localparam logic [31:0] R2_KEY = 32'd2029;
    localparam logic [31:0] E_KEY  = 32'd17;
    localparam logic [31:0] D_KEY  = 32'd2753;

    logic       clk, rst;
    logic [7:0] in_data;
    logic       in_valid, tgt_wd, out_ready, wd_out_ready;
    logic       m_in_valid, w_in_valid, rdy_mux;
    logic       in_ready, out_valid, busy, err;
    logic [7:0] out_data;
    logic       wd_in_ready, wd_out_valid, wd_busy, wd_err;
    logic [7:0] wd_out_data;
    int         n_vec, n_bad, err_cnt, ov_cnt, wd_err_cnt, wd_ov_cnt;

    assign m_in_valid = in_valid && !tgt_wd;
    assign w_in_valid = in_valid && tgt_wd;
    assign rdy_mux    = tgt_wd ? wd_in_ready : in_ready;

    rsa_stream_engine #(.BITS(32), .W(8), .NSLOT(2), .MAX_CYC(65536)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(m_in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    rsa_stream_engine #(.BITS(32), .W(8), .NSLOT(2), .MAX_CYC(16)) dut_wd (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(w_in_valid), .in_ready(wd_in_ready),
        .out_data(wd_out_data), .out_valid(wd_out_valid), .out_ready(wd_out_ready), .busy(wd_busy),
        .err(wd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err)          err_cnt++;
        if (out_valid)    ov_cnt++;
        if (wd_err)       wd_err_cnt++;
        if (wd_out_valid) wd_ov_cnt++;
    end

    // Called at a negedge; returns at the negedge after the word was taken.
    task automatic send_word(input logic [7:0] d);
        int k;
        in_data  = d;
        in_valid = 1'b1;
        k = 0;
        while (!rdy_mux && k < 6000) begin @(negedge clk); k++; end
        if (!rdy_mux) begin
            n_vec++; n_bad++;
            $display("[TB] FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", k);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] hdr, input logic [31:0] val);
        send_word(hdr);
        for (int i = 0; i < 4; i++) send_word(val[i*8 +: 8]);
    endtask

    task automatic recv_result(output logic [31:0] val, output bit ok);
        int k;
        val = '0;
        ok = 1'b1;
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            k = 0;
            while (!out_valid && k < 5000) begin @(negedge clk); k++; end
            if (!out_valid) begin
                n_vec++; n_bad++;
                $display("[TB] FAIL recv_timeout word %0d: out_valid=0, expected 1", w);
                ok = 1'b0;
                return;
            end
            val[w*8 +: 8] = out_data;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (in_ready !== 1'b0)  begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
        n_vec++; if (busy !== 1'b0)      begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (err !== 1'b0)       begin n_bad++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1)  begin n_bad++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (busy !== 1'b0)      begin n_bad++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_encrypt;
        logic [31:0] v, want;
        bit ok;
        want = 32'h0000_0AE6;
        send_cmd(8'h00, N_KEY);
        send_cmd(8'h40, R2_KEY);
        send_cmd(8'h80, E_KEY);
        send_cmd(8'hC0, 32'd65);
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL run_in_ready: got %b want 0", in_ready); end
        n_vec++; if (busy !== 1'b1)     begin n_bad++; $display("[TB] FAIL run_busy: got %b want 1", busy); end
        recv_result(v, ok);
        if (ok) begin
            for (int w = 0; w < 4; w++) begin
                n_vec++;
                if (v[w*8 +: 8] !== want[w*8 +: 8]) begin
                    n_bad++; $display("[TB] FAIL encrypt_word%0d: got %h want %h", w, v[w*8 +: 8], want[w*8 +: 8]);
                end
            end
        end
        n_vec++; if (busy !== 1'b0)      begin n_bad++; $display("[TB] FAIL encrypt_done_busy: got %b want 0", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL encrypt_done_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_decrypt;
        logic [31:0] v;
        bit ok;
        send_cmd(8'h81, D_KEY);
        send_cmd(8'hC1, 32'd2790);
        recv_result(v, ok);
        if (ok) begin
            n_vec++; if (v !== 32'h0000_0041) begin n_bad++; $display("[TB] FAIL decrypt_value: got %h want 00000041", v); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]  pat, prev;
        logic [31:0] got_val;
        logic        stall;
        int          got, cyc, k, ob;
        pat = 8'b1010_1001;
        out_ready = 1'b0;
        send_cmd(8'hC0, 32'd65);
        k = 0;
        while (!out_valid && k < 5000) begin @(negedge clk); k++; end
        got = 0; cyc = 0; stall = 1'b0; prev = '0; got_val = '0;
        ob = ov_cnt;
        while (got < 4 && cyc < 8) begin
            if (stall) begin
                n_vec++;
                if (out_data !== prev) begin n_bad++; $display("[TB] FAIL stall_stable cyc%0d: got %h want %h", cyc, out_data, prev); end
            end
            out_ready = pat[cyc];
            if (out_valid && out_ready) begin got_val[got*8 +: 8] = out_data; got++; end
            stall = out_valid && !out_ready;
            prev  = out_data;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (got !== 4)                begin n_bad++; $display("[TB] FAIL bp_count: got %0d words want 4", got); end
        n_vec++; if (got_val !== 32'h0000_0AE6) begin n_bad++; $display("[TB] FAIL bp_value: got %h want 00000ae6", got_val); end
        n_vec++; if (ov_cnt - ob !== 8)        begin n_bad++; $display("[TB] FAIL bp_valid_cycles: got %0d want 8", ov_cnt - ob); end
    endtask

    task automatic test_missing_key;
        logic [31:0] v;
        bit ok;
        int eb, ob;
        apply_reset;
        out_ready = 1'b1;
        send_cmd(8'h00, N_KEY);
        send_cmd(8'h40, R2_KEY);
        send_cmd(8'h80, E_KEY);
        eb = err_cnt; ob = ov_cnt;
        send_cmd(8'hC1, 32'd2790);
        repeat (10) @(negedge clk);
        n_vec++; if (err_cnt - eb !== 1) begin n_bad++; $display("[TB] FAIL nokey_err: got %0d pulses want 1", err_cnt - eb); end
        n_vec++; if (ov_cnt - ob !== 0)  begin n_bad++; $display("[TB] FAIL nokey_valid: got %0d cycles want 0", ov_cnt - ob); end
        n_vec++; if (in_ready !== 1'b1)  begin n_bad++; $display("[TB] FAIL nokey_ready: got %b want 1", in_ready); end
        send_cmd(8'h85, 32'h1234_5678);
        send_cmd(8'hC2, 32'd65);
        repeat (10) @(negedge clk);
        n_vec++; if (err_cnt - eb !== 3) begin n_bad++; $display("[TB] FAIL badslot_err: got %0d pulses want 3", err_cnt - eb); end
        n_vec++; if (ov_cnt - ob !== 0)  begin n_bad++; $display("[TB] FAIL badslot_valid: got %0d cycles want 0", ov_cnt - ob); end
        send_cmd(8'hC0, 32'd65);
        recv_result(v, ok);
        if (ok) begin
            n_vec++; if (v !== 32'h0000_0AE6) begin n_bad++; $display("[TB] FAIL slot0_after_err: got %h want 00000ae6", v); end
        end
    endtask

    task automatic test_watchdog;
        int k, eb, ob;
        tgt_wd = 1'b1;
        send_cmd(8'h00, N_KEY);
        send_cmd(8'h40, R2_KEY);
        send_cmd(8'h80, E_KEY);
        eb = wd_err_cnt; ob = wd_ov_cnt;
        send_cmd(8'hC0, 32'd65);
        k = 0;
        while (!wd_err && k < 100) begin @(negedge clk); k++; end
        // one START cycle plus sixteen WAIT cycles precede the ERR cycle
        n_vec++; if (k !== 17) begin n_bad++; $display("[TB] FAIL wd_latency: err after %0d cycles want 17", k); end
        @(negedge clk);
        n_vec++; if (wd_err !== 1'b0)        begin n_bad++; $display("[TB] FAIL wd_err_width: got %b want 0", wd_err); end
        n_vec++; if (wd_in_ready !== 1'b1)   begin n_bad++; $display("[TB] FAIL wd_ready: got %b want 1", wd_in_ready); end
        n_vec++; if (wd_busy !== 1'b0)       begin n_bad++; $display("[TB] FAIL wd_busy: got %b want 0", wd_busy); end
        n_vec++; if (wd_err_cnt - eb !== 1)  begin n_bad++; $display("[TB] FAIL wd_err_count: got %0d want 1", wd_err_cnt - eb); end
        n_vec++; if (wd_ov_cnt - ob !== 0)   begin n_bad++; $display("[TB] FAIL wd_no_output: got %0d want 0", wd_ov_cnt - ob); end
        n_vec++; if (wd_out_data !== 8'h00)  begin n_bad++; $display("[TB] FAIL wd_out_data: got %h want 00", wd_out_data); end
        tgt_wd = 1'b0;
    endtask

    task automatic test_reset_during_send;
        int k, eb, ob;
        out_ready = 1'b0;
        send_cmd(8'hC0, 32'd65);
        k = 0;
        while (!out_valid && k < 5000) begin @(negedge clk); k++; end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL word2_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_bad++; $display("[TB] FAIL word2_data: got %h want 00", out_data); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL async_valid_drop: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0)      begin n_bad++; $display("[TB] FAIL async_busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b0)  begin n_bad++; $display("[TB] FAIL async_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        eb = err_cnt; ob = ov_cnt;
        send_cmd(8'hC0, 32'd65);
        repeat (10) @(negedge clk);
        n_vec++; if (err_cnt - eb !== 1) begin n_bad++; $display("[TB] FAIL cleared_keys_err: got %0d pulses want 1", err_cnt - eb); end
        n_vec++; if (ov_cnt - ob !== 0)  begin n_bad++; $display("[TB] FAIL cleared_keys_valid: got %0d cycles want 0", ov_cnt - ob); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0;
        in_data = '0; in_valid = 1'b0; tgt_wd = 1'b0;
        out_ready = 1'b0; wd_out_ready = 1'b1;
        n_vec = 0; n_bad = 0;
        err_cnt = 0; ov_cnt = 0; wd_err_cnt = 0; wd_ov_cnt = 0;
        test_reset;
        test_encrypt;
        test_decrypt;
        test_backpressure;
        test_missing_key;
        test_watchdog;
        test_reset_during_send;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
